vga_timing_gen: RTL and testbench

Raster timing generator for the VGA path; it sits directly upstream of the image storage stage. It produces the `HDraw`/`VDraw` active-region qualifiers that image storage consumes to step through pixel data. It also produces sync pulses, pixel coordinates and line/frame strobes for the DAC/output stage. Horizontal and vertical phase sequencing runs on a pixel-rate clock enable, with all outputs registered.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_axis_counter.sv | 68 ++++++
 rtl/vga_timing_gen.sv | 68 ++++++
 tb/tb_vga_timing_gen.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared raster timing constants, phase encoding and total-length derivation
// for the VGA timing generator.
package vga_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FRONT  = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BACK   = 2'd3
   } phase_t;

   function automatic int axis_total(input int act, input int fp, input int syn, input int bp);
      return act + fp + syn + bp;
   endfunction

   localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus phase FSM with registered active/sync flags.
//   state     | meaning
//   PH_ACTIVE | visible region, active=1
//   PH_FRONT  | front porch
//   PH_SYNC   | sync pulse, sync=1
//   PH_BACK   | back porch, wraps to PH_ACTIVE after last position
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE = DEF_H_ACTIVE,
   parameter int FP     = DEF_H_FP,
   parameter int SYNC   = DEF_H_SYNC,
   parameter int BP     = DEF_H_BP,
   parameter int CNT_W  = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             restart,
   input  logic             step,
   output logic [CNT_W-1:0] count,
   output logic             active,
   output logic             sync,
   output logic             wrap
);

   localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
   localparam logic [CNT_W-1:0] END_A = CNT_W'(ACTIVE - 1);
   localparam logic [CNT_W-1:0] END_F = CNT_W'(ACTIVE + FP - 1);
   localparam logic [CNT_W-1:0] END_S = CNT_W'(ACTIVE + FP + SYNC - 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);

   phase_t phase;

   assign wrap = (count == LAST);

   // restart presents position 0 without advancing, so the flags come up with the count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         phase  <= PH_ACTIVE;
         active <= 1'b0;
         sync   <= 1'b0;
      end else if (restart || (step && wrap)) begin
         count  <= '0;
         phase  <= PH_ACTIVE;
         active <= 1'b1;
         sync   <= 1'b0;
      end else if (step) begin
         count <= count + 1'b1;
         case (phase)
            PH_ACTIVE: if (count == END_A) begin
               phase  <= PH_FRONT;
               active <= 1'b0;
            end
            PH_FRONT: if (count == END_F) begin
               phase <= PH_SYNC;
               sync  <= 1'b1;
            end
            PH_SYNC: if (count == END_S) begin
               phase <= PH_BACK;
               sync  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical axis counters stepped by the
// pixel enable, with active qualifiers, sync levels and line/frame strobes.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic SYNC_POL = 1'b0,
   parameter int   CNT_W    = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic             HDraw,
   output logic             VDraw,
   output logic             hsync,
   output logic             vsync,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             line_start,
   output logic             frame_start
);

   logic running;
   logic restart, h_step, v_step;
   logic h_sync, v_sync, h_wrap, v_wrap;

   // first enabled edge after reset only presents (0,0); later edges advance
   assign restart = en & ~running;
   assign h_step  = en & running;
   assign v_step  = h_step & h_wrap;

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(CNT_W)
   ) u_h (
      .clk(clk), .rst_n(rst), .restart(restart), .step(h_step),
      .count(hcount), .active(HDraw), .sync(h_sync), .wrap(h_wrap)
   );

   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(CNT_W)
   ) u_v (
      .clk(clk), .rst_n(rst), .restart(restart), .step(v_step),
      .count(vcount), .active(VDraw), .sync(v_sync), .wrap(v_wrap)
   );

   assign hsync = h_sync ? SYNC_POL : ~SYNC_POL;
   assign vsync = v_sync ? SYNC_POL : ~SYNC_POL;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         running     <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= en & (~running | h_wrap);
         frame_start <= en & (~running | (h_wrap & v_wrap));
         if (en) running <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny active-high-sync
// instance, both compared every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst;
   logic en;

   logic       hd0, vd0, hs0, vs0, ls0, fs0;
   logic [9:0] hc0, vc0;
   logic       hd1, vd1, hs1, vs1, ls1, fs1;
   logic [3:0] hc1, vc1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vga_timing_gen u_dut0 (
      .clk(clk), .rst(rst), .en(en),
      .HDraw(hd0), .VDraw(vd0), .hsync(hs0), .vsync(vs0),
      .hcount(hc0), .vcount(vc0), .line_start(ls0), .frame_start(fs0)
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(1'b1), .CNT_W(4)
   ) u_dut1 (
      .clk(clk), .rst(rst), .en(en),
      .HDraw(hd1), .VDraw(vd1), .hsync(hs1), .vsync(vs1),
      .hcount(hc1), .vcount(vc1), .line_start(ls1), .frame_start(fs1)
   );

   // raster description per instance: active, front porch, sync, back porch
   int ha[2] = '{640, 4};
   int hf[2] = '{16, 1};
   int hw[2] = '{96, 2};
   int hb[2] = '{48, 1};
   int va[2] = '{480, 3};
   int vf[2] = '{10, 1};
   int vw[2] = '{2, 1};
   int vb[2] = '{33, 1};
   bit pol[2] = '{1'b0, 1'b1};

   int mh[2], mv[2];
   bit st[2], mls[2], mfs[2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mh[i] = 0; mv[i] = 0; st[i] = 0; mls[i] = 0; mfs[i] = 0;
      end
   endtask

   task automatic model_edge(input bit e);
      for (int i = 0; i < 2; i++) begin
         if (!rst) continue;
         if (!e) begin
            mls[i] = 0; mfs[i] = 0;
         end else if (!st[i]) begin
            st[i] = 1; mh[i] = 0; mv[i] = 0; mls[i] = 1; mfs[i] = 1;
         end else begin
            mh[i]++;
            if (mh[i] == ha[i] + hf[i] + hw[i] + hb[i]) begin
               mh[i] = 0;
               mv[i]++;
               if (mv[i] == va[i] + vf[i] + vw[i] + vb[i]) mv[i] = 0;
            end
            mls[i] = (mh[i] == 0);
            mfs[i] = (mh[i] == 0) && (mv[i] == 0);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_inst(input int i, input logic hd, input logic vd, input logic hs,
                           input logic vs, input logic [31:0] hc, input logic [31:0] vc,
                           input logic l, input logic f);
      bit in_hs, in_vs;
      in_hs = st[i] && mh[i] >= ha[i] + hf[i] && mh[i] < ha[i] + hf[i] + hw[i];
      in_vs = st[i] && mv[i] >= va[i] + vf[i] && mv[i] < va[i] + vf[i] + vw[i];
      chk($sformatf("d%0d.hcount", i), hc, 32'(mh[i]));
      chk($sformatf("d%0d.vcount", i), vc, 32'(mv[i]));
      chk($sformatf("d%0d.HDraw@%0d", i, mh[i]), 32'(hd), 32'(st[i] && mh[i] < ha[i]));
      chk($sformatf("d%0d.VDraw@%0d", i, mv[i]), 32'(vd), 32'(st[i] && mv[i] < va[i]));
      chk($sformatf("d%0d.hsync@%0d", i, mh[i]), 32'(hs), 32'(in_hs ? pol[i] : !pol[i]));
      chk($sformatf("d%0d.vsync@%0d", i, mv[i]), 32'(vs), 32'(in_vs ? pol[i] : !pol[i]));
      chk($sformatf("d%0d.line_start", i), 32'(l), 32'(mls[i]));
      chk($sformatf("d%0d.frame_start", i), 32'(f), 32'(mfs[i]));
   endtask

   task automatic check_all();
      chk_inst(0, hd0, vd0, hs0, vs0, 32'(hc0), 32'(vc0), ls0, fs0);
      chk_inst(1, hd1, vd1, hs1, vs1, 32'(hc1), 32'(vc1), ls1, fs1);
   endtask

   task automatic cyc(input bit e);
      en = e;
      @(posedge clk);
      model_edge(e);
      #1;
      check_all();
   endtask

   initial begin
      rst = 1'b0;
      en  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b1;

      // enable low: nothing starts
      cyc(0);
      cyc(0);
      // first enabled edge presents (0,0) with both strobes
      cyc(1);
      chk("first.frame_start", 32'(fs0), 32'd1);
      chk("first.HDraw", 32'(hd0), 32'd1);

      // run to the end of the first line, then hold across the wrap
      for (int k = 0; k < 2000 && mh[0] != 798; k++) cyc(1);
      chk("reach.h798", 32'(hc0), 32'd798);
      cyc(1);
      cyc(0);
      cyc(0);
      chk("hold.h799", 32'(hc0), 32'd799);
      cyc(1);
      chk("wrap.line_start", 32'(ls0), 32'd1);
      chk("wrap.vcount", 32'(vc0), 32'd1);
      cyc(1);
      chk("wrap.line_start_drop", 32'(ls0), 32'd0);

      // randomized enable pattern over a few lines / many small frames
      repeat (2500) cyc($urandom_range(0, 3) != 0);

      // asynchronous reset mid-frame
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_all();
      cyc(1);
      cyc(1);
      rst = 1'b1;
      cyc(1);
      chk("restart.frame_start", 32'(fs1), 32'd1);

      repeat (1500) cyc($urandom_range(0, 4) != 0);
      repeat (200) cyc(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
